uart_rx_monitor: RTL and testbench

Parametrised successor of the bench UART receive model. It samples a serial line and supports configurable bit period, data width, parity and stop bits. Received characters go into a first-word-fall-through FIFO, with error flags and a character counter. It sits in the chip-level bench on the chip UART TX line, or in-chip as a debug sniffer, so benches can drain and check characters instead of only printing them.

---
 rtl/uart_rx_monitor.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: serial receive monitor with configurable bit period,
// character format, parity and stop bits. Completed characters land in a
// first-word-fall-through FIFO; per-frame error pulses, a sticky overrun
// flag and a wrapping character counter report line health.
module uart_rx_monitor #(
  parameter int DIV        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 rx_busy,
  output logic                 rx_end,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic [15:0]          char_count
);

  localparam int DW = $clog2(DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_ZERO  = DW'(0);
  localparam logic [DW-1:0] DIV_ONE   = DW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity check: even mode flags an odd total, odd mode flags an even total.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 pbit);
    logic total;
    total = (^data) ^ pbit;
    return (PARITY == 2) ? ~total : total;
  endfunction

  logic                 rx_meta_r, rxs_r;
  state_t               state_r, state_n;
  logic [DW-1:0]        div_cnt_r, div_cnt_n;
  logic [3:0]           bit_cnt_r, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_r, shift_n;
  logic                 par_flag_r, par_flag_n;
  logic                 frm_flag_r, frm_flag_n;
  logic                 done_s, frame_bad_s;

  logic                 rx_end_r, parity_err_r, frame_err_r, overrun_r, rx_busy_r;
  logic [15:0]          char_count_r;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_r, rd_ptr_r;
  logic                 empty_s, full_s, pop_s, push_req_s, push_s, ovr_set_s;

  // Two-flop synchroniser on the serial input; idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Receive FSM state register and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      div_cnt_r  <= DIV_ZERO;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_flag_r <= 1'b0;
      frm_flag_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      div_cnt_r  <= div_cnt_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      par_flag_r <= par_flag_n;
      frm_flag_r <= frm_flag_n;
    end
  end

  // Next-state logic: mid-bit sampling aligned by the half-period start check.
  always_comb begin
    state_n     = state_r;
    div_cnt_n   = div_cnt_r;
    bit_cnt_n   = bit_cnt_r;
    shift_n     = shift_r;
    par_flag_n  = par_flag_r;
    frm_flag_n  = frm_flag_r;
    done_s      = 1'b0;
    frame_bad_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_r) begin
          state_n   = START;
          div_cnt_n = DIV_ZERO;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (div_cnt_r == HALF_LAST) begin
          if (rxs_r) begin
            state_n = IDLE;            // start bit did not hold: glitch
          end else begin
            state_n    = DATA;
            div_cnt_n  = DIV_ZERO;
            bit_cnt_n  = 4'd0;
            par_flag_n = 1'b0;
            frm_flag_n = 1'b0;
          end
        end else begin
          div_cnt_n = div_cnt_r + DIV_ONE;
        end
      end
      DATA: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_n = DIV_ZERO;
          shift_n   = {rxs_r, shift_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_n = 4'd0;
            state_n   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end
        end else begin
          div_cnt_n = div_cnt_r + DIV_ONE;
        end
      end
      PAR: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_n  = DIV_ZERO;
          bit_cnt_n  = 4'd0;
          par_flag_n = parity_mismatch(shift_r, rxs_r);
          state_n    = STOP;
        end else begin
          div_cnt_n = div_cnt_r + DIV_ONE;
        end
      end
      STOP: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_n  = DIV_ZERO;
          frm_flag_n = frm_flag_r | ~rxs_r;
          if (bit_cnt_r == STOP_LAST) begin
            // Return to IDLE now so a start edge later in this bit is caught.
            bit_cnt_n   = 4'd0;
            state_n     = IDLE;
            done_s      = 1'b1;
            frame_bad_s = frm_flag_r | ~rxs_r;
          end else begin
            bit_cnt_n = bit_cnt_r + 4'd1;
          end
        end else begin
          div_cnt_n = div_cnt_r + DIV_ONE;
        end
      end
      default: begin
        state_n   = IDLE;
        div_cnt_n = DIV_ZERO;
        bit_cnt_n = 4'd0;
      end
    endcase
  end

  // FIFO occupancy flags and push/pop arbitration for the completing frame.
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = rd_en & ~empty_s;
    push_req_s = done_s & ~frame_bad_s;
    if (push_req_s) begin
      push_s    = ~full_s | pop_s;
      ovr_set_s = full_s & ~pop_s;
    end else begin
      push_s    = 1'b0;
      ovr_set_s = 1'b0;
    end
  end

  // FIFO storage; contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
    end
  end

  // FIFO pointers with natural wrap of the extra lap bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Registered completion pulses, counter, busy and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_end_r     <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      rx_busy_r    <= 1'b0;
      char_count_r <= 16'd0;
    end else begin
      rx_end_r     <= done_s;
      parity_err_r <= done_s & par_flag_r;
      frame_err_r  <= done_s & frame_bad_s;
      rx_busy_r    <= (state_n != IDLE);
      if (done_s) begin
        char_count_r <= char_count_r + 16'd1;
      end
      if (ovr_set_s) begin
        overrun_r <= 1'b1;               // a new drop beats a clear
      end else if (clr_err) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign rd_data    = empty_s ? {DATA_BITS{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign empty      = empty_s;
  assign full       = full_s;
  assign rx_busy    = rx_busy_r;
  assign rx_end     = rx_end_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign char_count = char_count_r;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed bench for three receiver configurations
// (defaults; 7-bit even parity; 4-deep FIFO with two stop bits).
module tb_uart_rx_monitor;

  localparam int DIV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int start_cyc = 0;

  logic reset_a, rx_a, rd_en_a, clr_err_a;
  logic reset_b, rx_b, rd_en_b, clr_err_b;
  logic reset_c, rx_c, rd_en_c, clr_err_c;

  logic [7:0]  rd_data_a, rd_data_c;
  logic [6:0]  rd_data_b;
  logic        empty_a, full_a, busy_a, end_a, perr_a, ferr_a, ovr_a;
  logic        empty_b, full_b, busy_b, end_b, perr_b, ferr_b, ovr_b;
  logic        empty_c, full_c, busy_c, end_c, perr_c, ferr_c, ovr_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  uart_rx_monitor #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset(reset_a), .rx(rx_a), .rd_en(rd_en_a), .clr_err(clr_err_a),
    .rd_data(rd_data_a), .empty(empty_a), .full(full_a), .rx_busy(busy_a), .rx_end(end_a),
    .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a), .char_count(cnt_a));

  uart_rx_monitor #(.DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .reset(reset_b), .rx(rx_b), .rd_en(rd_en_b), .clr_err(clr_err_b),
    .rd_data(rd_data_b), .empty(empty_b), .full(full_b), .rx_busy(busy_b), .rx_end(end_b),
    .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b), .char_count(cnt_b));

  uart_rx_monitor #(.DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset_c), .rx(rx_c), .rd_en(rd_en_c), .clr_err(clr_err_c),
    .rd_data(rd_data_c), .empty(empty_c), .full(full_c), .rx_busy(busy_c), .rx_end(end_c),
    .parity_err(perr_c), .frame_err(ferr_c), .overrun(ovr_c), .char_count(cnt_c));

  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Capture completion pulses and the flags that accompany them.
  int n_end_a = 0, n_end_b = 0, n_end_c = 0;
  int end_cyc_a = 0, end_cyc_b = 0, end_cyc_c = 0;
  logic last_perr_a = 1'b0, last_ferr_a = 1'b0;
  logic last_perr_b = 1'b0, last_ferr_b = 1'b0;
  int stray = 0;
  always @(negedge clk) begin
    if (end_a) begin n_end_a++; end_cyc_a = cyc; last_perr_a = perr_a; last_ferr_a = ferr_a; end
    if (end_b) begin n_end_b++; end_cyc_b = cyc; last_perr_b = perr_b; last_ferr_b = ferr_b; end
    if (end_c) begin n_end_c++; end_cyc_c = cyc; end
    if ((perr_a | ferr_a) & ~end_a) stray++;
    if ((perr_b | ferr_b) & ~end_b) stray++;
    if ((perr_c | ferr_c) & ~end_c) stray++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v);
    case (sel)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic pop(input int sel);
    case (sel)
      0: rd_en_a = 1'b1;
      1: rd_en_b = 1'b1;
      default: rd_en_c = 1'b1;
    endcase
    @(negedge clk);
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame; called on a falling clock edge, returns on one.
  task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                            input int par, input logic par_bad, input int nstop,
                            input logic stop_val);
    logic pbit;
    start_cyc = cyc;
    drive(sel, 1'b0);
    idle(DIV);
    pbit = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      drive(sel, data[i]);
      pbit = pbit ^ data[i];
      idle(DIV);
    end
    if (par != 0) begin
      if (par == 2) pbit = ~pbit;
      drive(sel, pbit ^ par_bad);
      idle(DIV);
    end
    for (int i = 0; i < nstop; i++) begin
      drive(sel, stop_val);
      idle(DIV);
    end
    drive(sel, 1'b1);
  endtask

  function automatic int lat_exp(input int db, input int p, input int sb);
    return 2 + DIV / 2 + DIV * (db + p + sb - 1) + DIV + 1;
  endfunction

  initial begin
    int lat;
    logic [7:0] exp_q [4];
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
    clr_err_a = 1'b0; clr_err_b = 1'b0; clr_err_c = 1'b0;
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;
    idle(3);
    chk("rst_empty", {31'd0, empty_a}, 32'd1);
    chk("rst_full", {31'd0, full_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_end", {31'd0, end_a}, 32'd0);
    chk("rst_ovr", {31'd0, ovr_a}, 32'd0);
    chk("rst_cnt", {16'd0, cnt_a}, 32'd0);
    chk("rst_rd", {24'd0, rd_data_a}, 32'd0);
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    idle(4);

    // Default configuration: single character, then drain it.
    send_frame(0, 8'h41, 8, 0, 1'b0, 1, 1'b1);
    idle(4);
    lat = end_cyc_a - start_cyc;
    chk("a_end_cnt", n_end_a, 32'd1);
    chk("a_latency", {31'd0, (lat >= lat_exp(8, 0, 1) - 1) && (lat <= lat_exp(8, 0, 1) + 1)}, 32'd1);
    chk("a_rd_41", {24'd0, rd_data_a}, 32'h41);
    chk("a_empty0", {31'd0, empty_a}, 32'd0);
    chk("a_cnt1", {16'd0, cnt_a}, 32'd1);
    chk("a_ferr_ok", {31'd0, last_ferr_a}, 32'd0);
    pop(0);
    chk("a_empty_pop", {31'd0, empty_a}, 32'd1);
    chk("a_rd_zero", {24'd0, rd_data_a}, 32'd0);

    // Stop bit low: counted, flagged, discarded.
    send_frame(0, 8'hA5, 8, 0, 1'b0, 1, 1'b0);
    idle(2 * DIV);
    chk("a_ferr_end", n_end_a, 32'd2);
    chk("a_ferr_flag", {31'd0, last_ferr_a}, 32'd1);
    chk("a_ferr_cnt", {16'd0, cnt_a}, 32'd2);
    chk("a_ferr_empty", {31'd0, empty_a}, 32'd1);

    // Leave a character queued, then a start glitch.
    send_frame(0, 8'h3C, 8, 0, 1'b0, 1, 1'b1);
    idle(4);
    chk("a_rd_3c", {24'd0, rd_data_a}, 32'h3C);
    rx_a = 1'b0;
    idle(DIV / 2 - 2);
    rx_a = 1'b1;
    idle(3 * DIV);
    chk("glitch_end", n_end_a, 32'd3);
    chk("glitch_busy", {31'd0, busy_a}, 32'd0);
    chk("glitch_cnt", {16'd0, cnt_a}, 32'd3);

    // Reset in the middle of a data bit with a character in the FIFO.
    rx_a = 1'b0;
    idle(DIV);
    rx_a = 1'b1;
    idle(2 * DIV);
    chk("mid_busy", {31'd0, busy_a}, 32'd1);
    reset_a = 1'b0;
    #1;
    chk("mid_rst_empty", {31'd0, empty_a}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_cnt", {16'd0, cnt_a}, 32'd0);
    chk("mid_rst_rd", {24'd0, rd_data_a}, 32'd0);
    chk("mid_rst_flags", {28'd0, end_a, perr_a, ferr_a, ovr_a}, 32'd0);
    @(negedge clk);
    reset_a = 1'b1;
    idle(2 * DIV);
    send_frame(0, 8'h96, 8, 0, 1'b0, 1, 1'b1);
    idle(4);
    chk("post_rst_rd", {24'd0, rd_data_a}, 32'h96);
    chk("post_rst_cnt", {16'd0, cnt_a}, 32'd1);

    // Counter wrap from preloaded 0xFFFF.
    force dut_a.char_count_r = 16'hFFFF;
    @(negedge clk);
    release dut_a.char_count_r;
    send_frame(0, 8'h12, 8, 0, 1'b0, 1, 1'b1);
    idle(4);
    chk("cnt_wrap", {16'd0, cnt_a}, 32'd0);
    chk("wrap_end", n_end_a, 32'd5);

    // Even parity, 7 data bits.
    send_frame(1, 8'h55, 7, 1, 1'b0, 1, 1'b1);
    idle(4);
    lat = end_cyc_b - start_cyc;
    chk("b_end1", n_end_b, 32'd1);
    chk("b_latency", {31'd0, (lat >= lat_exp(7, 1, 1) - 1) && (lat <= lat_exp(7, 1, 1) + 1)}, 32'd1);
    chk("b_perr_ok", {31'd0, last_perr_b}, 32'd0);
    chk("b_rd_55", {25'd0, rd_data_b}, 32'h55);
    pop(1);
    send_frame(1, 8'h55, 7, 1, 1'b1, 1, 1'b1);
    idle(4);
    chk("b_end2", n_end_b, 32'd2);
    chk("b_perr_bad", {31'd0, last_perr_b}, 32'd1);
    chk("b_ferr_bad", {31'd0, last_ferr_b}, 32'd0);
    chk("b_kept_empty", {31'd0, empty_b}, 32'd0);
    chk("b_kept_rd", {25'd0, rd_data_b}, 32'h55);

    // 4-deep FIFO, two stop bits: fill, overflow, clear.
    for (int k = 1; k <= 5; k++) begin
      send_frame(2, 8'(k), 8, 0, 1'b0, 2, 1'b1);
      idle(4);
      if (k == 1) begin
        lat = end_cyc_c - start_cyc;
        chk("c_latency", {31'd0, (lat >= lat_exp(8, 0, 2) - 1) && (lat <= lat_exp(8, 0, 2) + 1)}, 32'd1);
      end
      if (k == 3) chk("c_full_3", {31'd0, full_c}, 32'd0);
      if (k == 4) begin
        chk("c_full_4", {31'd0, full_c}, 32'd1);
        chk("c_ovr_4", {31'd0, ovr_c}, 32'd0);
      end
      if (k == 5) begin
        chk("c_ovr_5", {31'd0, ovr_c}, 32'd1);
        chk("c_full_5", {31'd0, full_c}, 32'd1);
        chk("c_cnt_5", {16'd0, cnt_c}, 32'd5);
      end
    end
    clr_err_c = 1'b1;
    @(negedge clk);
    clr_err_c = 1'b0;
    chk("c_clr", {31'd0, ovr_c}, 32'd0);

    // Pop exactly on the completion edge while full.
    fork
      send_frame(2, 8'h06, 8, 0, 1'b0, 2, 1'b1);
      begin
        idle(lat_exp(8, 0, 2) - 1);
        rd_en_c = 1'b1;
        @(negedge clk);
        rd_en_c = 1'b0;
      end
    join
    idle(4);
    chk("c_pushpop_ovr", {31'd0, ovr_c}, 32'd0);
    chk("c_pushpop_full", {31'd0, full_c}, 32'd1);
    chk("c_end6", n_end_c, 32'd6);
    exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h06;
    for (int i = 0; i < 4; i++) begin
      chk("c_drain", {24'd0, rd_data_c}, {24'd0, exp_q[i]});
      pop(2);
    end
    chk("c_drained", {31'd0, empty_c}, 32'd1);
    pop(2);
    chk("c_pop_empty", {31'd0, empty_c}, 32'd1);

    // Back-to-back frames with no idle gap.
    send_frame(2, 8'hFF, 8, 0, 1'b0, 2, 1'b1);
    send_frame(2, 8'h00, 8, 0, 1'b0, 2, 1'b1);
    idle(4);
    chk("b2b_end", n_end_c, 32'd8);
    chk("b2b_ff", {24'd0, rd_data_c}, 32'hFF);
    pop(2);
    chk("b2b_00_present", {31'd0, empty_c}, 32'd0);
    chk("b2b_00", {24'd0, rd_data_c}, 32'h00);
    pop(2);
    chk("b2b_empty", {31'd0, empty_c}, 32'd1);
    chk("stray_flags", stray, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
